mdu_hilo: RTL and testbench

- Multiply/divide unit with architectural HI/LO registers, in the Execute stage of the 5-stage MIPS pipeline.
- Consumes the Execute-stage MDU controls from the decoder: start, op, HI write and LO write, plus forwarded rs/rt operands.
- Runs mult/multu/div/divu over a fixed multi-cycle latency and exposes busy to the hazard unit.
- Provides HI/LO read values for mfhi/mflo.

---
 rtl/mdu_hilo.sv | 132 +++++++++++++
 tb/tb_mdu_hilo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo - multiply/divide unit with architectural HI/LO registers.
//
// Sits in the Execute stage. A single-cycle MDU_Start pulse launches
// mult/multu/div/divu. The full result is computed at launch into pHI/pLO
// and held back until the busy period ends. This gives the op its fixed
// latency, and the result is committed to HI/LO in one step at the end.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   MDU_Start     launch pulse (ignored unless IDLE and MDU_Op <= 3)
//   MDU_Op        0=mult 1=multu 2=div 3=divu, 4..7 no operation
//   MDU_HI_Write  mthi: HI <= A (IDLE, no start)
//   MDU_LO_Write  mtlo: LO <= A (IDLE, no start)
//   A, B          forwarded rs / rt operands
//   Busy          operation in flight
//   HI, LO        architectural HI/LO
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no op in flight; accepts start or mthi/mtlo
// RUN   | op in flight; cnt = remaining busy cycles, commit at cnt==1

module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDU_Start,
  input  logic [2:0]  MDU_Op,
  input  logic        MDU_HI_Write,
  input  logic        MDU_LO_Write,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [31:0]     p_hi, p_lo;
  logic            launch, done;

  logic [63:0]     a_sx, b_sx, prod_s, prod_u;
  logic [31:0]     a_mag, b_mag, b_safe, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic            a_neg, b_neg;
  logic [31:0]     res_hi, res_lo;

  assign launch = (state == IDLE) && MDU_Start && !MDU_Op[2];
  assign done   = (state == RUN) && (cnt == CW'(1));
  assign Busy   = (state == RUN);

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes. This keeps 0x80000000 / -1 well defined:
  // the magnitude quotient 0x80000000 negates back to itself.
  // b_safe avoids a divide by zero; the result is discarded in that case.
  assign a_neg  = A[31];
  assign b_neg  = B[31];
  assign a_mag  = a_neg ? (~A + 32'd1) : A;
  assign b_mag  = b_neg ? (~B + 32'd1) : B;
  assign b_safe = (B == 32'd0) ? 32'd1 : B;
  assign q_mag  = a_mag / ((b_mag == 32'd0) ? 32'd1 : b_mag);
  assign r_mag  = a_mag % ((b_mag == 32'd0) ? 32'd1 : b_mag);
  assign q_s    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = a_neg ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = A / b_safe;
  assign r_u    = A % b_safe;

  always_comb begin
    res_hi = HI;
    res_lo = LO;
    case (MDU_Op[1:0])
      2'd0: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      2'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      2'd2: if (B != 32'd0) begin res_hi = r_s; res_lo = q_s; end
      default: if (B != 32'd0) begin res_hi = r_u; res_lo = q_u; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      if (launch) begin
        cnt  <= MDU_Op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        p_hi <= res_hi;
        p_lo <= res_lo;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
      end

      if (done) begin
        HI <= p_hi;
        LO <= p_lo;
      end else if ((state == IDLE) && !MDU_Start) begin
        if (MDU_HI_Write) HI <= A;
        if (MDU_LO_Write) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: a table of arithmetic vectors plus
// random vectors from a reference model, all scored through an expected-result
// queue. Hand-written sequences then cover mthi/mtlo, divide by zero, writes
// during RUN, reserved ops and reset mid-operation.

module tb_mdu_hilo;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, MDU_Start, MDU_HI_Write, MDU_LO_Write;
  logic [2:0]  MDU_Op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDU_Start(MDU_Start), .MDU_Op(MDU_Op),
    .MDU_HI_Write(MDU_HI_Write), .MDU_LO_Write(MDU_LO_Write),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] hi_m, lo_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint          ps;
    longint unsigned pu;
    int              sa, sd;
    e.cyc = op[1] ? DC : MC;
    e.hi  = hi_m;
    e.lo  = lo_m;
    case (op)
      3'd0: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        e.hi = ps[63:32]; e.lo = ps[31:0];
      end
      3'd1: begin
        pu = longint'(a) * longint'(b);
        e.hi = pu[63:32]; e.lo = pu[31:0];
      end
      3'd2: if (b != 0) begin
        sa = a; sd = b;
        e.lo = sa / sd; e.hi = sa % sd;
      end
      default: if (b != 0) begin
        e.lo = a / b; e.hi = a % b;
      end
    endcase
    return e;
  endfunction

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    @(negedge clk);
    MDU_Start = 1'b1; MDU_Op = op; A = a; B = b;
    e.hi = ehi; e.lo = elo; e.cyc = op[1] ? DC : MC;
    sbq.push_back(e);
    @(negedge clk);
    MDU_Start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; n0 cycles already elapsed.
  task automatic drain(input string name, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (Busy === 1'b1 && n < 100) begin
      check({name, " hold HI"}, HI, hi_m);
      check({name, " hold LO"}, LO, lo_m);
      n++;
      @(negedge clk);
    end
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty at completion", name);
    end else begin
      e = sbq.pop_front();
      check({name, " busy cycles"}, 32'(n), 32'(e.cyc));
      check({name, " HI"}, HI, e.hi);
      check({name, " LO"}, LO, e.lo);
      hi_m = e.hi;
      lo_m = e.lo;
    end
  endtask

  initial begin
    exp_t        e;
    logic [2:0]  op;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[6] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

    reset = 1'b1; MDU_Start = 1'b0; MDU_Op = 3'd0;
    MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset Busy", 32'(Busy), 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    hi_m = '0; lo_m = '0;

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      drain($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (rb == 0) rb = 32'd1;
      if (op == 3'd2 && ra == 32'h8000_0000) ra = 32'd1;
      e = model(op, ra, rb);
      launch(op, ra, rb, e.hi, e.lo);
      drain($sformatf("rnd%0d", i), 0);
    end

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    MDU_HI_Write = 1'b1; A = 32'h0000_1234;
    @(negedge clk);
    MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b1; A = 32'h0000_5678;
    check("mthi HI", HI, 32'h0000_1234);
    check("mthi Busy", 32'(Busy), 32'd0);
    @(negedge clk);
    MDU_LO_Write = 1'b0;
    check("mtlo HI", HI, 32'h0000_1234);
    check("mtlo LO", LO, 32'h0000_5678);
    check("mtlo Busy", 32'(Busy), 32'd0);
    hi_m = 32'h0000_1234; lo_m = 32'h0000_5678;

    // divide by zero: full busy period, HI/LO unchanged
    launch(3'd2, 32'h0000_0037, 32'd0, 32'h0000_1234, 32'h0000_5678);
    drain("div0", 0);

    // mthi/mtlo during RUN are ignored
    launch(3'd0, 32'd3, 32'd4, 32'd0, 32'd12);
    MDU_HI_Write = 1'b1; MDU_LO_Write = 1'b1; A = 32'h0000_DEAD;
    @(negedge clk);
    MDU_HI_Write = 1'b0; MDU_LO_Write = 1'b0;
    drain("mthi_in_run", 1);

    // reserved op: no operation
    @(negedge clk);
    MDU_Start = 1'b1; MDU_Op = 3'd5; A = 32'd9; B = 32'd3;
    @(negedge clk);
    MDU_Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("op5 Busy", 32'(Busy), 32'd0);
      check("op5 LO", LO, lo_m);
      @(negedge clk);
    end

    // reset during RUN at busy cycle 4
    @(negedge clk);
    MDU_Start = 1'b1; MDU_Op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    MDU_Start = 1'b0;
    check("rst_run Busy c1", 32'(Busy), 32'd1);
    repeat (3) @(negedge clk);
    check("rst_run Busy c4", 32'(Busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_run Busy", 32'(Busy), 32'd0);
    check("rst_run HI", HI, 32'd0);
    check("rst_run LO", LO, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_run late HI", HI, 32'd0);
      check("rst_run late LO", LO, 32'd0);
      check("rst_run late Busy", 32'(Busy), 32'd0);
    end

    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
